// File: rtl/snn_io_pkg.sv
// Shared types and image constants for the image RAM loader/unloader pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snn_io_pkg;

   localparam int IMG_BITS   = 784;
   localparam int ADDR_WIDTH = 10;
   localparam int BYTE_WIDTH = 8;
   localparam int IMG_BYTES  = IMG_BITS / BYTE_WIDTH;

   // Last valid RAM address of the 28x28 image.
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = 10'h30F;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      SEND    = 3'd2,
      WAIT_TX = 3'd3,
      DONE    = 3'd4
   } dump_state_t;

endpackage

// File: rtl/dump_input_file_bit_packer.sv
// Serial-in/parallel-out byte register: writes one bit at a given index when enabled.
// Latency: captured bit visible on shift_q the cycle after cap_en; shift_d shows it combinationally.
// Backpressure: none; the caller decides when to capture.
// Ports: cap_en/cap_idx/cap_bit select and supply the bit, shift_q is the held byte,
//        shift_d is the byte including any capture happening this cycle.
module bit_packer #(
   parameter int WIDTH = 8,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cap_en,
   input  logic [IDX_W-1:0] cap_idx,
   input  logic             cap_bit,
   output logic [WIDTH-1:0] shift_q,
   output logic [WIDTH-1:0] shift_d
);

   always_comb begin
      shift_d = shift_q;
      if (cap_en) begin
         shift_d[cap_idx] = cap_bit;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_q <= '0;
      end else begin
         shift_q <= shift_d;
      end
   end

endmodule

// File: rtl/dump_input_file.sv
// Reads the 1-bit image RAM in address order, packs 8 bits LSB-first per byte, and
// hands each byte to the UART TX. Latency: 9 fetch cycles + 1 send cycle per byte, plus TX time.
// Backpressure: holds tx_data and stops reading until tx_done; start is ignored while busy.
// Ports: start/busy/done control; ram_addr/ram_q image RAM read port (1-cycle read);
//        tx_data/tx_start/tx_done UART TX handshake.
module dump_input_file
   import snn_io_pkg::*;
#(
   parameter int IMG_BITS   = snn_io_pkg::IMG_BITS,
   parameter int ADDR_WIDTH = snn_io_pkg::ADDR_WIDTH,
   parameter int BYTE_WIDTH = snn_io_pkg::BYTE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic                  ram_q,
   output logic [BYTE_WIDTH-1:0] tx_data,
   output logic                  tx_start,
   input  logic                  tx_done,
   output logic                  busy,
   output logic                  done
);

   localparam int N_BYTES = IMG_BITS / BYTE_WIDTH;
   localparam int IDX_W   = $clog2(BYTE_WIDTH);
   localparam int FCNT_W  = $clog2(BYTE_WIDTH + 1);
   localparam int BCNT_W  = $clog2(N_BYTES + 1);

   // fetch_cnt runs 0..BYTE_WIDTH: addresses go out on counts 0..7, the last bit lands on count 8.
   localparam logic [FCNT_W-1:0] FETCH_LAST = FCNT_W'(BYTE_WIDTH);
   localparam logic [FCNT_W-1:0] ISSUE_LAST = FCNT_W'(BYTE_WIDTH - 1);
   localparam logic [BCNT_W-1:0] BYTES_LAST = BCNT_W'(N_BYTES);

   dump_state_t           state_q, state_d;
   logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
   logic [BCNT_W-1:0]     byte_cnt_q, byte_cnt_d;
   logic [FCNT_W-1:0]     fetch_cnt_q, fetch_cnt_d;
   logic                  cap_vld_q, cap_vld_d;
   logic [IDX_W-1:0]      cap_idx_q, cap_idx_d;
   logic [BYTE_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  tx_start_q, tx_start_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [BYTE_WIDTH-1:0] pack_q;
   logic [BYTE_WIDTH-1:0] pack_d;

   // Capture is delayed one cycle behind the address so it lines up with the RAM read data.
   bit_packer #(
      .WIDTH (BYTE_WIDTH),
      .IDX_W (IDX_W)
   ) u_packer (
      .clk     (clk),
      .rst_n   (rst_n),
      .cap_en  (cap_vld_q),
      .cap_idx (cap_idx_q),
      .cap_bit (ram_q),
      .shift_q (pack_q),
      .shift_d (pack_d)
   );

   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      byte_cnt_d  = byte_cnt_q;
      fetch_cnt_d = fetch_cnt_q;
      cap_vld_d   = 1'b0;
      cap_idx_d   = cap_idx_q;
      tx_data_d   = tx_data_q;
      tx_start_d  = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = FETCH;
               cur_addr_d  = '0;
               byte_cnt_d  = '0;
               fetch_cnt_d = '0;
            end
         end
         FETCH: begin
            fetch_cnt_d = fetch_cnt_q + 1'b1;
            if (fetch_cnt_q < FETCH_LAST) begin
               cap_vld_d = 1'b1;
               cap_idx_d = fetch_cnt_q[IDX_W-1:0];
            end
            // Address parks on 8k+7 rather than stepping past it, so the final
            // byte never presents an address beyond the image.
            if (fetch_cnt_q < ISSUE_LAST) begin
               cur_addr_d = cur_addr_q + 1'b1;
            end
            if (fetch_cnt_q == FETCH_LAST) begin
               state_d    = SEND;
               tx_data_d  = pack_d;   // includes the bit landing this cycle
               tx_start_d = 1'b1;
            end
         end
         SEND: begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = WAIT_TX;
         end
         WAIT_TX: begin
            if (tx_done) begin
               if (byte_cnt_q == BYTES_LAST) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d     = FETCH;
                  fetch_cnt_d = '0;
                  cur_addr_d  = ADDR_WIDTH'(byte_cnt_q) << IDX_W;
               end
            end
         end
         DONE: begin
            state_d    = IDLE;
            cur_addr_d = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cur_addr_q  <= '0;
         byte_cnt_q  <= '0;
         fetch_cnt_q <= '0;
         cap_vld_q   <= 1'b0;
         cap_idx_q   <= '0;
         tx_data_q   <= '0;
         tx_start_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         byte_cnt_q  <= byte_cnt_d;
         fetch_cnt_q <= fetch_cnt_d;
         cap_vld_q   <= cap_vld_d;
         cap_idx_q   <= cap_idx_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign ram_addr = (state_q == FETCH) ? cur_addr_q : '0;
   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
